// File: rtl/ocl_reg_bank.sv
`timescale 1ns/1ps
// ocl_reg_bank: AXI-Lite slave register bank on the OCL BAR0 path.
// Word-indexed map: ID, synchronised VDIP, VLED, free-running CYCLE,
// CONTROL (clears CYCLE) and full-width SCRATCH registers.
// AW and W are captured in independent one-entry buffers; a write commits
// the cycle after both are full, while the response is raised in that same
// cycle so the master sees bvalid one cycle after its last handshake.
module ocl_reg_bank #(
    parameter int                NUM_REGS = 16,
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                VLED_W   = 16,
    parameter int                VDIP_W   = 16,
    parameter logic [DATA_W-1:0] ID_VALUE = '0
) (
    input  logic                clk_main_a0,
    input  logic                rst_main_n,

    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,

    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,

    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,

    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,

    output logic                rvalid,
    input  logic                rready,
    output logic [1:0]          rresp,
    output logic [DATA_W-1:0]   rdata,

    input  logic [VDIP_W-1:0]   vdip,
    output logic [VLED_W-1:0]   vled
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [IDX_W-1:0] REG_ID    = IDX_W'(0);
    localparam logic [IDX_W-1:0] REG_VDIP  = IDX_W'(1);
    localparam logic [IDX_W-1:0] REG_VLED  = IDX_W'(2);
    localparam logic [IDX_W-1:0] REG_CYCLE = IDX_W'(3);
    localparam logic [IDX_W-1:0] REG_CTRL  = IDX_W'(4);

    // Write response for a decoded word index; RO registers reject writes.
    function automatic logic [1:0] wr_resp(input logic [IDX_W-1:0] idx, input logic oor);
        if (oor)
            return RESP_DECERR;
        else if (idx == REG_ID || idx == REG_VDIP || idx == REG_CYCLE)
            return RESP_SLVERR;
        else
            return RESP_OKAY;
    endfunction

    // ---------------------------------------------------------------
    // Address decode: byte-offset bits are dropped, any set bit above
    // the index field makes the access out of range.
    // ---------------------------------------------------------------
    logic [IDX_W-1:0] awaddr_idx, araddr_idx;
    logic             awaddr_oor, araddr_oor;
    logic             unused_addr_bits;

    assign awaddr_idx       = awaddr[LSB +: IDX_W];
    assign araddr_idx       = araddr[LSB +: IDX_W];
    assign awaddr_oor       = |awaddr[ADDR_W-1:LSB+IDX_W];
    assign araddr_oor       = |araddr[ADDR_W-1:LSB+IDX_W];
    assign unused_addr_bits = ^{awaddr[LSB-1:0], araddr[LSB-1:0]};

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic                alive;
    logic                aw_full, w_full;
    logic [IDX_W-1:0]    aw_idx;
    logic                aw_oor;
    logic [DATA_W-1:0]   w_data;
    logic [STRB_W-1:0]   w_strb;

    logic [VDIP_W-1:0]   vdip_s1, vdip_s2;
    logic [VLED_W-1:0]   vled_reg;
    logic [DATA_W-1:0]   cycle_cnt;
    logic [DATA_W-1:0]   scratch [NUM_REGS];

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic wr_go, wr_ok, b_set, cyc_clr;
    logic [IDX_W-1:0]  pend_idx;
    logic              pend_oor;
    logic [DATA_W-1:0] wmask, vled_ext, vdip_ext, vled_new, rd_val;

    assign awready = alive & ~aw_full & ~bvalid;
    assign wready  = alive & ~w_full  & ~bvalid;
    assign arready = alive & ~rvalid;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid  & wready;
    assign ar_hs = arvalid & arready;
    assign b_hs  = bvalid  & bready;
    assign r_hs  = rvalid  & rready;

    // Both halves present: commit this cycle and release the buffers.
    assign wr_go = aw_full & w_full;
    assign wr_ok = (wr_resp(aw_idx, aw_oor) == RESP_OKAY);

    // The response is raised on the last of the two handshakes, so its
    // address may still be on the bus rather than in the buffer.
    assign pend_idx = aw_full ? aw_idx : awaddr_idx;
    assign pend_oor = aw_full ? aw_oor : awaddr_oor;
    assign b_set    = ~bvalid & ((aw_hs & (w_full | w_hs)) | (w_hs & aw_full));

    assign cyc_clr = wr_go & wr_ok & (aw_idx == REG_CTRL) & w_strb[0] & w_data[0];

    // Byte-enable expansion and zero-extended views of the narrow registers.
    always_comb begin
        wmask    = '0;
        vled_ext = '0;
        vdip_ext = '0;
        for (int b = 0; b < STRB_W; b++)
            wmask[8*b +: 8] = {8{w_strb[b]}};
        vled_ext[VLED_W-1:0] = vled_reg;
        vdip_ext[VDIP_W-1:0] = vdip_s2;
        vled_new = (vled_ext & ~wmask) | (w_data & wmask);
    end

    // Readys stay low until the first edge after reset release.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n)
            alive <= 1'b0;
        else
            alive <= 1'b1;
    end

    // Write-address holding register.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            aw_full <= 1'b0;
            aw_idx  <= '0;
            aw_oor  <= 1'b0;
        end else if (aw_hs) begin
            aw_full <= 1'b1;
            aw_idx  <= awaddr_idx;
            aw_oor  <= awaddr_oor;
        end else if (wr_go) begin
            aw_full <= 1'b0;
        end
    end

    // Write-data holding register.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            w_full <= 1'b0;
            w_data <= '0;
            w_strb <= '0;
        end else if (w_hs) begin
            w_full <= 1'b1;
            w_data <= wdata;
            w_strb <= wstrb;
        end else if (wr_go) begin
            w_full <= 1'b0;
        end
    end

    // Write response channel; bresp holds until the bready handshake.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
        end else if (b_set) begin
            bvalid <= 1'b1;
            bresp  <= wr_resp(pend_idx, pend_oor);
        end else if (b_hs) begin
            bvalid <= 1'b0;
        end
    end

    // Writable registers: VLED (low bits only) and SCRATCH, byte-masked.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            vled_reg <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                scratch[i] <= '0;
        end else if (wr_go && wr_ok) begin
            if (aw_idx == REG_VLED)
                vled_reg <= vled_new[VLED_W-1:0];
            for (int i = 5; i < NUM_REGS; i++)
                if (aw_idx == IDX_W'(i))
                    scratch[i] <= (scratch[i] & ~wmask) | (w_data & wmask);
        end
    end

    // Free-running cycle counter; a CONTROL clear beats the increment.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n)
            cycle_cnt <= '0;
        else if (cyc_clr)
            cycle_cnt <= '0;
        else
            cycle_cnt <= cycle_cnt + DATA_W'(1);
    end

    // Two-flop synchroniser for the asynchronous DIP input.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            vdip_s1 <= '0;
            vdip_s2 <= '0;
        end else begin
            vdip_s1 <= vdip;
            vdip_s2 <= vdip_s1;
        end
    end

    // Registered LED output, one cycle behind the VLED register.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n)
            vled <= '0;
        else
            vled <= vled_reg;
    end

    // Read mux on the live read address; out of range reads as zero.
    always_comb begin
        rd_val = '0;
        if (!araddr_oor) begin
            case (araddr_idx)
                REG_ID:    rd_val = ID_VALUE;
                REG_VDIP:  rd_val = vdip_ext;
                REG_VLED:  rd_val = vled_ext;
                REG_CYCLE: rd_val = cycle_cnt;
                REG_CTRL:  rd_val = '0;
                default:   rd_val = scratch[araddr_idx];
            endcase
        end
    end

    // Read data channel: captured at the AR handshake, held until rready.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            rvalid <= 1'b0;
            rresp  <= RESP_OKAY;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rresp  <= araddr_oor ? RESP_DECERR : RESP_OKAY;
            rdata  <= rd_val;
        end else if (r_hs) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ocl_reg_bank.sv
`timescale 1ns/1ps
// tb_ocl_reg_bank: directed and randomized AXI-Lite traffic against a
// register-map model held in plain arrays.
module tb_ocl_reg_bank;
    localparam int          NUM_REGS = 16;
    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 32;
    localparam int          VLED_W   = 16;
    localparam int          VDIP_W   = 16;
    localparam logic [31:0] ID_VAL   = 32'hF00D_CAFE;

    logic              clk_main_a0 = 1'b0;
    logic              rst_main_n  = 1'b0;
    logic              awvalid = 1'b0, awready;
    logic [ADDR_W-1:0] awaddr  = '0;
    logic              wvalid  = 1'b0, wready;
    logic [DATA_W-1:0] wdata   = '0;
    logic [3:0]        wstrb   = '0;
    logic              bvalid, bready = 1'b0;
    logic [1:0]        bresp;
    logic              arvalid = 1'b0, arready;
    logic [ADDR_W-1:0] araddr  = '0;
    logic              rvalid, rready = 1'b0;
    logic [1:0]        rresp;
    logic [DATA_W-1:0] rdata;
    logic [VDIP_W-1:0] vdip = '0;
    logic [VLED_W-1:0] vled;

    ocl_reg_bank #(
        .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .VLED_W(VLED_W), .VDIP_W(VDIP_W), .ID_VALUE(ID_VAL)
    ) dut (
        .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata),
        .vdip(vdip), .vled(vled)
    );

    always #5 clk_main_a0 = ~clk_main_a0;

    int cyc = 0;
    always @(posedge clk_main_a0) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    // Reference model of the register map.
    logic [31:0] m_scr [NUM_REGS];
    logic [15:0] m_vled;
    logic [15:0] m_vdip;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < NUM_REGS; i++) m_scr[i] = '0;
        m_vled = '0;
    endtask

    function automatic logic [1:0] exp_wresp(input int idx);
        if (idx >= NUM_REGS) return 2'b11;
        if (idx == 0 || idx == 1 || idx == 3) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        return v;
    endfunction

    task automatic mdl_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] t;
        if (exp_wresp(idx) != 2'b00) return;
        if (idx == 2) begin
            t = merge({16'h0, m_vled}, d, s);
            m_vled = t[15:0];
        end else if (idx >= 5) begin
            m_scr[idx] = merge(m_scr[idx], d, s);
        end
    endtask

    function automatic logic [31:0] exp_rdata(input int idx);
        if (idx >= NUM_REGS) return 32'h0;
        case (idx)
            0:       return ID_VAL;
            1:       return {16'h0, m_vdip};
            2:       return {16'h0, m_vled};
            4:       return 32'h0;
            default: return m_scr[idx];
        endcase
    endfunction

    // Full write transaction with independent AW/W start delays and a
    // bready hold; checks response timing, stability and the model resp.
    task automatic axi_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_hold);
        bit aw_done = 0, w_done = 0, aw_hit, w_hit;
        int t = 0;
        logic [1:0] er = exp_wresp(idx);
        awaddr = 32'(idx * 4 + int'($urandom_range(0, 3)));
        wdata  = d;
        wstrb  = s;
        while (!(aw_done && w_done) && t < 100) begin
            awvalid = !aw_done && (t >= aw_dly);
            wvalid  = !w_done  && (t >= w_dly);
            aw_hit  = awvalid && awready;
            w_hit   = wvalid && wready;
            @(posedge clk_main_a0); #1;
            t++;
            if (aw_hit) aw_done = 1;
            if (w_hit)  w_done  = 1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("wr_handshake", 64'(aw_done && w_done), 64'(1));
        chk("bvalid_lat", 64'(bvalid), 64'(1));
        chk("bresp", 64'(bresp), 64'(er));
        for (int i = 0; i < b_hold; i++) begin
            @(posedge clk_main_a0); #1;
            chk("bhold_valid", 64'(bvalid), 64'(1));
            chk("bhold_resp", 64'(bresp), 64'(er));
            chk("bhold_awready", 64'(awready), 64'(0));
            chk("bhold_wready", 64'(wready), 64'(0));
        end
        bready = 1'b1;
        @(posedge clk_main_a0); #1;
        bready = 1'b0;
        chk("b_done", 64'(bvalid), 64'(0));
        chk("awready_after_b", 64'(awready), 64'(1));
        mdl_write(idx, d, s);
    endtask

    // Full read transaction; returns data/resp and the tb cycle of the
    // AR handshake edge.
    task automatic axi_read(input int idx, input int r_hold, output logic [31:0] d,
                            output logic [1:0] r, output int hs_cyc);
        bit hit = 0;
        int t = 0;
        araddr  = 32'(idx * 4 + int'($urandom_range(0, 3)));
        arvalid = 1'b1;
        while (!hit && t < 100) begin
            hit = arready;
            @(posedge clk_main_a0); #1;
            t++;
        end
        hs_cyc  = cyc;
        arvalid = 1'b0;
        chk("rd_handshake", 64'(hit), 64'(1));
        chk("rvalid_lat", 64'(rvalid), 64'(1));
        d = rdata;
        r = rresp;
        for (int i = 0; i < r_hold; i++) begin
            @(posedge clk_main_a0); #1;
            chk("rhold_valid", 64'(rvalid), 64'(1));
            chk("rhold_data", 64'(rdata), 64'(d));
            chk("rhold_arready", 64'(arready), 64'(0));
        end
        rready = 1'b1;
        @(posedge clk_main_a0); #1;
        rready = 1'b0;
        chk("r_done", 64'(rvalid), 64'(0));
    endtask

    task automatic read_chk(input string tag, input int idx);
        logic [31:0] d;
        logic [1:0]  r;
        int          h;
        axi_read(idx, 0, d, r, h);
        chk(tag, 64'(d), 64'(exp_rdata(idx)));
        chk({tag, "_resp"}, 64'(r), 64'(idx >= NUM_REGS ? 2'b11 : 2'b00));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_main_a0);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d, c1, c2;
        logic [1:0]  r;
        int          h1, h2;
        bit          hit;
        int          t;

        mdl_reset();
        m_vdip = '0;

        // Reset values
        idle(2);
        chk("rst_awready", 64'(awready), 64'(0));
        chk("rst_wready",  64'(wready),  64'(0));
        chk("rst_arready", 64'(arready), 64'(0));
        chk("rst_bvalid",  64'(bvalid),  64'(0));
        chk("rst_rvalid",  64'(rvalid),  64'(0));
        chk("rst_resps",   64'({bresp, rresp}), 64'(0));
        chk("rst_rdata",   64'(rdata),   64'(0));
        chk("rst_vled",    64'(vled),    64'(0));
        rst_main_n = 1'b1;
        chk("alive_pre", 64'({awready, wready, arready}), 64'(0));
        idle(1);
        chk("alive_post", 64'({awready, wready, arready}), 64'(3'b111));
        idle(3);

        read_chk("id", 0);

        // Byte strobes, W leading AW by 3 cycles
        axi_write(5, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_write(5, 32'h1234_5678, 4'b0101, 3, 0, 0);
        read_chk("scratch_strb", 5);
        chk("scratch_strb_abs", 64'(m_scr[5]), 64'(32'hFF34_FF78));

        // Long bready backpressure
        axi_write(6, 32'hDEAD_BEEF, 4'hF, 0, 2, 5);
        read_chk("scratch6", 6);

        // RO and out-of-range accesses
        vdip = 16'h3C3C; m_vdip = 16'h3C3C;
        idle(3);
        axi_write(1, 32'h0000_FFFF, 4'hF, 0, 0, 0);
        read_chk("vdip", 1);
        axi_write(0, 32'h1111_1111, 4'hF, 1, 0, 0);
        read_chk("id_after_wr", 0);
        axi_write(NUM_REGS, 32'h5555_5555, 4'hF, 0, 0, 0);
        read_chk("oor", NUM_REGS);

        // VLED: register reaches the pin one cycle after the write completes
        axi_write(2, 32'hFFFF_A5A5, 4'hF, 0, 0, 0);
        chk("vled_pre", 64'(vled), 64'(0));
        idle(1);
        chk("vled", 64'(vled), 64'(16'hA5A5));
        read_chk("vled_reg", 2);

        // CYCLE increments once per cycle, then clear via CONTROL
        axi_read(3, 0, c1, r, h1);
        idle(int'($urandom_range(1, 20)));
        axi_read(3, 1, c2, r, h2);
        chk("cycle_delta", 64'(c2 - c1), 64'(h2 - h1));
        axi_write(4, 32'h1, 4'h1, 0, 0, 0);
        axi_read(3, 0, c1, r, h1);
        chk("cycle_cleared", 64'(c1 < 32'd8), 64'(1));

        // Read and write commit to the same register in one cycle
        axi_write(8, 32'hAAAA_0001, 4'hF, 0, 0, 0);
        awaddr = 32'(8 * 4); wdata = 32'hBBBB_0002; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        chk("cc_ready", 64'({awready, wready}), 64'(2'b11));
        idle(1);
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'(8 * 4); arvalid = 1'b1;
        chk("cc_arready", 64'(arready), 64'(1));
        idle(1);
        arvalid = 1'b0;
        chk("cc_rdata_old", 64'(rdata), 64'(32'hAAAA_0001));
        chk("cc_bvalid", 64'(bvalid), 64'(1));
        bready = 1'b1; rready = 1'b1;
        idle(1);
        bready = 1'b0; rready = 1'b0;
        mdl_write(8, 32'hBBBB_0002, 4'hF);
        read_chk("cc_new", 8);

        // Reset mid-transaction drops a half-complete write
        axi_write(9, 32'h0909_0909, 4'hF, 0, 0, 0);
        awaddr = 32'(7 * 4); awvalid = 1'b1;
        hit = 0; t = 0;
        while (!hit && t < 50) begin hit = awready; idle(1); t++; end
        awvalid = 1'b0;
        chk("mid_aw_hs", 64'(hit), 64'(1));
        chk("mid_aw_full", 64'(awready), 64'(0));
        rst_main_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'({awready, wready, arready, bvalid, rvalid}), 64'(0));
        chk("mid_rst_vled", 64'(vled), 64'(0));
        mdl_reset();
        idle(2);
        rst_main_n = 1'b1;
        idle(2);
        wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1;
        hit = 0; t = 0;
        while (!hit && t < 50) begin hit = wready; idle(1); t++; end
        wvalid = 1'b0;
        idle(3);
        chk("mid_no_commit", 64'(bvalid), 64'(0));
        awaddr = 32'(10 * 4); awvalid = 1'b1;
        hit = 0; t = 0;
        while (!hit && t < 50) begin hit = awready; idle(1); t++; end
        awvalid = 1'b0;
        chk("mid_late_b", 64'(bvalid), 64'(1));
        bready = 1'b1; idle(1); bready = 1'b0;
        mdl_write(10, 32'h7777_7777, 4'hF);
        read_chk("mid_s9", 9);
        read_chk("mid_s10", 10);

        // Randomized traffic
        vdip = 16'($urandom); m_vdip = vdip;
        idle(3);
        for (int n = 0; n < 60; n++) begin
            int idx = int'($urandom_range(0, NUM_REGS + 1));
            if ($urandom_range(0, 1) == 0) begin
                axi_write(idx, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            end else begin
                axi_read(idx, int'($urandom_range(0, 2)), d, r, h1);
                chk("rnd_rresp", 64'(r), 64'(idx >= NUM_REGS ? 2'b11 : 2'b00));
                if (idx != 3)
                    chk("rnd_rdata", 64'(d), 64'(exp_rdata(idx)));
            end
        end
        idle(2);
        chk("rnd_vled", 64'(vled), 64'(m_vled));
        for (int i = 5; i < NUM_REGS; i++)
            read_chk("rnd_final", i);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
